// File: rtl/odd_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module   : odd_fwd_stage
//  Purpose  : Register-fetch / forwarding stage in front of the odd pipe
//             (Permute / LocalStore / Branch). Captures the decoded odd
//             instruction and its register-file operands, repairs stale
//             operands from write-back while holding, and resolves operand
//             bypass from the odd/even fw staging arrays.
//  Ports    : clk, reset (async, active-low)
//             in_*            decoded instruction + RF read values
//             stall, flush    hold / kill control
//             odd_/even_fw_*  fw staging values, addresses, write enables
//             odd_/even_*_wb  write-back ports (RF write this cycle)
//             op..first, ra/rb/rt_st, reg_write, out_valid -> odd pipe
//  Revision : 1.0  initial release
// ============================================================================
module odd_fwd_stage #(
    parameter int DATA_W   = 128,
    parameter int ADDR_W   = 7,
    parameter int FW_DEPTH = 7
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [10:0]                      in_op,
    input  logic [2:0]                       in_format,
    input  logic [1:0]                       in_unit,
    input  logic [ADDR_W-1:0]                in_rt_addr,
    input  logic [ADDR_W-1:0]                in_ra_addr,
    input  logic [ADDR_W-1:0]                in_rb_addr,
    input  logic [ADDR_W-1:0]                in_rc_addr,
    input  logic [DATA_W-1:0]                in_ra_rf,
    input  logic [DATA_W-1:0]                in_rb_rf,
    input  logic [DATA_W-1:0]                in_rc_rf,
    input  logic [17:0]                      in_imm,
    input  logic                             in_reg_write,
    input  logic [7:0]                       in_pc,
    input  logic                             in_first,
    input  logic                             stall,
    input  logic                             flush,
    input  logic [FW_DEPTH-1:0][DATA_W-1:0]  odd_fw_wb,
    input  logic [FW_DEPTH-1:0][ADDR_W-1:0]  odd_fw_addr,
    input  logic [FW_DEPTH-1:0]              odd_fw_write,
    input  logic [FW_DEPTH-1:0][DATA_W-1:0]  even_fw_wb,
    input  logic [FW_DEPTH-1:0][ADDR_W-1:0]  even_fw_addr,
    input  logic [FW_DEPTH-1:0]              even_fw_write,
    input  logic [DATA_W-1:0]                odd_rt_wb,
    input  logic [ADDR_W-1:0]                odd_rt_addr_wb,
    input  logic                             odd_wr_wb,
    input  logic [DATA_W-1:0]                even_rt_wb,
    input  logic [ADDR_W-1:0]                even_rt_addr_wb,
    input  logic                             even_wr_wb,
    output logic [10:0]                      op,
    output logic [2:0]                       format,
    output logic [1:0]                       unit,
    output logic [ADDR_W-1:0]                rt_addr,
    output logic [17:0]                      imm,
    output logic [7:0]                       pc_out,
    output logic                             first,
    output logic [DATA_W-1:0]                ra,
    output logic [DATA_W-1:0]                rb,
    output logic [DATA_W-1:0]                rt_st,
    output logic                             reg_write,
    output logic                             out_valid
);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic              valid_q,     valid_d;
    logic              reg_write_q, reg_write_d;
    logic [10:0]       op_q,        op_d;
    logic [2:0]        format_q,    format_d;
    logic [1:0]        unit_q,      unit_d;
    logic [ADDR_W-1:0] rt_addr_q,   rt_addr_d;
    logic [ADDR_W-1:0] ra_addr_q,   ra_addr_d;
    logic [ADDR_W-1:0] rb_addr_q,   rb_addr_d;
    logic [ADDR_W-1:0] rc_addr_q,   rc_addr_d;
    logic [DATA_W-1:0] ra_rf_q,     ra_rf_d;
    logic [DATA_W-1:0] rb_rf_q,     rb_rf_d;
    logic [DATA_W-1:0] rc_rf_q,     rc_rf_d;
    logic [17:0]       imm_q,       imm_d;
    logic [7:0]        pc_q,        pc_d;
    logic              first_q,     first_d;

    // Overlay a write-back landing this cycle onto an RF operand; odd wins.
    function automatic logic [DATA_W-1:0] wb_repair(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] val
    );
        logic [DATA_W-1:0] res;
        res = val;
        if (odd_wr_wb && (odd_rt_addr_wb == addr))
            res = odd_rt_wb;
        else if (even_wr_wb && (even_rt_addr_wb == addr))
            res = even_rt_wb;
        return res;
    endfunction

    // Forward from fw staging. Walk from oldest to youngest so the lowest
    // index is applied last; within an index even is applied before odd so
    // odd takes precedence. Entry 0 is never searched.
    function automatic logic [DATA_W-1:0] fw_resolve(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] rf_val
    );
        logic [DATA_W-1:0] res;
        res = rf_val;
        for (int i = FW_DEPTH - 1; i >= 1; i--) begin
            if (even_fw_write[i] && (even_fw_addr[i] == addr))
                res = even_fw_wb[i];
            if (odd_fw_write[i] && (odd_fw_addr[i] == addr))
                res = odd_fw_wb[i];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Next-state: flush > stall > load
    // ------------------------------------------------------------------
    always_comb begin
        // Hold by default, but keep captured operands fresh against write-back.
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        op_d        = op_q;
        format_d    = format_q;
        unit_d      = unit_q;
        rt_addr_d   = rt_addr_q;
        ra_addr_d   = ra_addr_q;
        rb_addr_d   = rb_addr_q;
        rc_addr_d   = rc_addr_q;
        ra_rf_d     = wb_repair(ra_addr_q, ra_rf_q);
        rb_rf_d     = wb_repair(rb_addr_q, rb_rf_q);
        rc_rf_d     = wb_repair(rc_addr_q, rc_rf_q);
        imm_d       = imm_q;
        pc_d        = pc_q;
        first_d     = first_q;

        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            op_d        = '0;
        end else if (!stall) begin
            valid_d     = in_valid;
            reg_write_d = in_reg_write & in_valid;
            op_d        = in_op;
            format_d    = in_format;
            unit_d      = in_unit;
            rt_addr_d   = in_rt_addr;
            ra_addr_d   = in_ra_addr;
            rb_addr_d   = in_rb_addr;
            rc_addr_d   = in_rc_addr;
            // RF read happened before the same-cycle write-back landed.
            ra_rf_d     = wb_repair(in_ra_addr, in_ra_rf);
            rb_rf_d     = wb_repair(in_rb_addr, in_rb_rf);
            rc_rf_d     = wb_repair(in_rc_addr, in_rc_rf);
            imm_d       = in_imm;
            pc_d        = in_pc;
            first_d     = in_first;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            op_q        <= '0;
            format_q    <= '0;
            unit_q      <= '0;
            rt_addr_q   <= '0;
            ra_addr_q   <= '0;
            rb_addr_q   <= '0;
            rc_addr_q   <= '0;
            ra_rf_q     <= '0;
            rb_rf_q     <= '0;
            rc_rf_q     <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            first_q     <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            op_q        <= op_d;
            format_q    <= format_d;
            unit_q      <= unit_d;
            rt_addr_q   <= rt_addr_d;
            ra_addr_q   <= ra_addr_d;
            rb_addr_q   <= rb_addr_d;
            rc_addr_q   <= rc_addr_d;
            ra_rf_q     <= ra_rf_d;
            rb_rf_q     <= rb_rf_d;
            rc_rf_q     <= rc_rf_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            first_q     <= first_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = valid_q;
    assign reg_write = reg_write_q;
    assign op        = op_q;
    assign format    = format_q;
    assign unit      = unit_q;
    assign rt_addr   = rt_addr_q;
    assign imm       = imm_q;
    assign pc_out    = pc_q;
    assign first     = first_q;

    // Combinational so forwarding follows results moving through fw stages
    // while this stage is stalled.
    assign ra    = fw_resolve(ra_addr_q, ra_rf_q);
    assign rb    = fw_resolve(rb_addr_q, rb_rf_q);
    assign rt_st = fw_resolve(rc_addr_q, rc_rf_q);

endmodule
`default_nettype wire

// File: tb/tb_odd_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_odd_fwd_stage
//  Purpose  : Directed self-checking bench for odd_fwd_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_odd_fwd_stage;

    localparam int DATA_W   = 128;
    localparam int ADDR_W   = 7;
    localparam int FW_DEPTH = 7;

    logic                             clk;
    logic                             reset;
    logic                             in_valid;
    logic [10:0]                      in_op;
    logic [2:0]                       in_format;
    logic [1:0]                       in_unit;
    logic [ADDR_W-1:0]                in_rt_addr, in_ra_addr, in_rb_addr, in_rc_addr;
    logic [DATA_W-1:0]                in_ra_rf, in_rb_rf, in_rc_rf;
    logic [17:0]                      in_imm;
    logic                             in_reg_write;
    logic [7:0]                       in_pc;
    logic                             in_first;
    logic                             stall, flush;
    logic [FW_DEPTH-1:0][DATA_W-1:0]  odd_fw_wb, even_fw_wb;
    logic [FW_DEPTH-1:0][ADDR_W-1:0]  odd_fw_addr, even_fw_addr;
    logic [FW_DEPTH-1:0]              odd_fw_write, even_fw_write;
    logic [DATA_W-1:0]                odd_rt_wb, even_rt_wb;
    logic [ADDR_W-1:0]                odd_rt_addr_wb, even_rt_addr_wb;
    logic                             odd_wr_wb, even_wr_wb;
    logic [10:0]                      op;
    logic [2:0]                       format;
    logic [1:0]                       unit;
    logic [ADDR_W-1:0]                rt_addr;
    logic [17:0]                      imm;
    logic [7:0]                       pc_out;
    logic                             first;
    logic [DATA_W-1:0]                ra, rb, rt_st;
    logic                             reg_write, out_valid;

    int checks   = 0;
    int failures = 0;

    localparam logic [DATA_W-1:0] VA = {4{32'hAAAA_0001}};
    localparam logic [DATA_W-1:0] VB = {4{32'hBBBB_0002}};
    localparam logic [DATA_W-1:0] VC = {4{32'hCCCC_0003}};
    localparam logic [DATA_W-1:0] VD = {4{32'hDDDD_0004}};
    localparam logic [DATA_W-1:0] VE = {4{32'hEEEE_0005}};
    localparam logic [DATA_W-1:0] VF = {4{32'hFFFF_0006}};
    localparam logic [DATA_W-1:0] VG = {4{32'h1234_0007}};
    localparam logic [DATA_W-1:0] VH = {4{32'h5678_0008}};
    localparam logic [DATA_W-1:0] VR = {4{32'h9ABC_0009}};
    localparam logic [DATA_W-1:0] VN = {4{32'h0F0F_000A}};

    odd_fwd_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FW_DEPTH(FW_DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
        .in_format(in_format), .in_unit(in_unit), .in_rt_addr(in_rt_addr),
        .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr),
        .in_ra_rf(in_ra_rf), .in_rb_rf(in_rb_rf), .in_rc_rf(in_rc_rf),
        .in_imm(in_imm), .in_reg_write(in_reg_write), .in_pc(in_pc),
        .in_first(in_first), .stall(stall), .flush(flush),
        .odd_fw_wb(odd_fw_wb), .odd_fw_addr(odd_fw_addr), .odd_fw_write(odd_fw_write),
        .even_fw_wb(even_fw_wb), .even_fw_addr(even_fw_addr), .even_fw_write(even_fw_write),
        .odd_rt_wb(odd_rt_wb), .odd_rt_addr_wb(odd_rt_addr_wb), .odd_wr_wb(odd_wr_wb),
        .even_rt_wb(even_rt_wb), .even_rt_addr_wb(even_rt_addr_wb), .even_wr_wb(even_wr_wb),
        .op(op), .format(format), .unit(unit), .rt_addr(rt_addr), .imm(imm),
        .pc_out(pc_out), .first(first), .ra(ra), .rb(rb), .rt_st(rt_st),
        .reg_write(reg_write), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        in_valid = 0; in_op = '0; in_format = '0; in_unit = '0;
        in_rt_addr = '0; in_ra_addr = '0; in_rb_addr = '0; in_rc_addr = '0;
        in_ra_rf = '0; in_rb_rf = '0; in_rc_rf = '0; in_imm = '0;
        in_reg_write = 0; in_pc = '0; in_first = 0; stall = 0; flush = 0;
        odd_fw_wb = '0; odd_fw_addr = '0; odd_fw_write = '0;
        even_fw_wb = '0; even_fw_addr = '0; even_fw_write = '0;
        odd_rt_wb = '0; odd_rt_addr_wb = '0; odd_wr_wb = 0;
        even_rt_wb = '0; even_rt_addr_wb = '0; even_wr_wb = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_all();
        reset = 1'b0;
        #12;
        // ---- reset state ----
        chk("rst_valid", out_valid, 0);
        chk("rst_regw",  reg_write, 0);
        chk("rst_op",    op, 0);
        chk("rst_pc",    pc_out, 0);
        chk("rst_ra",    ra, 0);
        reset = 1'b1;

        // ---- async reset mid-stream ----
        in_valid = 1; in_op = 11'h155; in_format = 3'd5; in_unit = 2'd2;
        in_rt_addr = 7'd33; in_imm = 18'h2_1234; in_reg_write = 1; in_pc = 8'h77;
        in_first = 1; in_ra_addr = 7'd12; in_ra_rf = VA;
        tick();
        chk("ld_valid", out_valid, 1);
        chk("ld_op",    op, 11'h155);
        chk("ld_fmt",   format, 3'd5);
        chk("ld_unit",  unit, 2'd2);
        chk("ld_rt",    rt_addr, 7'd33);
        chk("ld_imm",   imm, 18'h2_1234);
        chk("ld_first", first, 1);
        chk("ld_regw",  reg_write, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_regw",  reg_write, 0);
        chk("arst_op",    op, 0);
        chk("arst_pc",    pc_out, 0);
        chk("arst_imm",   imm, 0);
        chk("arst_ra",    ra, 0);
        @(negedge clk);
        reset = 1'b1;
        clear_all();

        // ---- fw hit, youngest wins ----
        in_valid = 1; in_ra_addr = 7'd5; in_ra_rf = VA;
        odd_fw_addr[4] = 7'd5; odd_fw_write[4] = 1; odd_fw_wb[4] = VB;
        tick();
        chk("fw_odd4", ra, VB);
        stall = 1;
        even_fw_addr[2] = 7'd5; even_fw_write[2] = 1; even_fw_wb[2] = VC;
        #1;
        chk("fw_even2_younger", ra, VC);
        odd_fw_write = '0; even_fw_write = '0;
        #1;
        chk("fw_nohit_rf", ra, VA);

        // ---- same-index tie, odd first; entry 0 ignored ----
        stall = 0; in_ra_addr = 7'd9; in_ra_rf = VE;
        tick();
        stall = 1;
        odd_fw_addr[3]  = 7'd9; odd_fw_write[3]  = 1; odd_fw_wb[3]  = VF;
        even_fw_addr[3] = 7'd9; even_fw_write[3] = 1; even_fw_wb[3] = VG;
        #1;
        chk("tie_odd", ra, VF);
        odd_fw_write[3] = 0;
        #1;
        chk("tie_even", ra, VG);
        even_fw_write[3] = 0;
        odd_fw_addr[0] = 7'd9; odd_fw_write[0] = 1; odd_fw_wb[0] = VH;
        even_fw_addr[0] = 7'd9; even_fw_write[0] = 1; even_fw_wb[0] = VH;
        #1;
        chk("entry0_ignored", ra, VE);
        // differs only in the MSB of the address: must not hit
        odd_fw_write[0] = 0; even_fw_write[0] = 0;
        odd_fw_addr[1] = 7'h49; odd_fw_write[1] = 1; odd_fw_wb[1] = VH;
        #1;
        chk("addr_full_width", ra, VE);
        odd_fw_write = '0;

        // ---- stall hold with write-back repair ----
        stall = 0; in_valid = 1; in_op = 11'h2AA; in_pc = 8'h44; in_imm = 18'h0_0ABC;
        in_rt_addr = 7'd20; in_reg_write = 1; in_rb_addr = 7'd7; in_rb_rf = VR;
        tick();
        stall = 1;
        in_op = 11'h7FF; in_pc = 8'hEE; in_rb_addr = 7'd1; in_rb_rf = VN; in_imm = 18'h3_FFFF;
        tick();
        chk("stall1_rb", rb, VR);
        chk("stall1_op", op, 11'h2AA);
        even_wr_wb = 1; even_rt_addr_wb = 7'd7; even_rt_wb = VD;
        tick();
        even_wr_wb = 0;
        chk("stall2_rb_repair", rb, VD);
        tick();
        chk("stall3_rb",  rb, VD);
        chk("stall3_op",  op, 11'h2AA);
        chk("stall3_pc",  pc_out, 8'h44);
        chk("stall3_imm", imm, 18'h0_0ABC);
        chk("stall3_rt",  rt_addr, 7'd20);
        chk("stall3_valid", out_valid, 1);
        // both write-back ports hit: odd wins
        odd_wr_wb = 1; odd_rt_addr_wb = 7'd7; odd_rt_wb = VH;
        even_wr_wb = 1; even_rt_addr_wb = 7'd7; even_rt_wb = VG;
        tick();
        odd_wr_wb = 0; even_wr_wb = 0;
        chk("wb_both_odd", rb, VH);

        // ---- repair of in_*_rf on a normal load ----
        stall = 0; in_rc_addr = 7'd3; in_rc_rf = VA;
        odd_wr_wb = 1; odd_rt_addr_wb = 7'd3; odd_rt_wb = VN;
        tick();
        odd_wr_wb = 0;
        chk("load_repair_rc", rt_st, VN);

        // ---- flush beats stall and in_valid ----
        flush = 1; stall = 1; in_valid = 1; in_reg_write = 1; in_op = 11'h123;
        tick();
        flush = 0; stall = 0;
        chk("flush_valid", out_valid, 0);
        chk("flush_regw",  reg_write, 0);
        chk("flush_op",    op, 0);

        // ---- back-to-back, 1-cycle latency ----
        in_valid = 1; in_reg_write = 1;
        for (int k = 0; k < 4; k++) begin
            in_pc = 8'h10 + 8'(k);
            tick();
            chk("b2b_pc", pc_out, 8'h10 + 8'(k));
            chk("b2b_valid", out_valid, 1);
        end
        in_valid = 0;
        tick();
        chk("tail_valid", out_valid, 0);
        chk("tail_regw",  reg_write, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
